// File: rtl/light_pkg.sv
// Shared lamp-controller definitions: state encodings used by the state
// controller and by the downstream lamp output decoder.
package light_pkg;

    typedef logic [1:0] light_state_t;

    // All four codes are legal; any nonzero state drives the lamp.
    localparam logic [1:0] ST_OFF      = 2'b00;
    localparam logic [1:0] ST_ON       = 2'b01;
    localparam logic [1:0] ST_HOLD     = 2'b10;
    localparam logic [1:0] ST_OVERRIDE = 2'b11;

    // Bit positions of the sensor bundle passed through the synchronizer.
    localparam int unsigned IN_MOTION = 0;
    localparam int unsigned IN_DARK   = 1;
    localparam int unsigned IN_MANUAL = 2;
    localparam int unsigned IN_W      = 3;

    // Lamp decode shared with the output decoder block.
    function automatic logic lamp_is_on(input light_state_t st);
        return st != ST_OFF;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bundle of independent asynchronous levels.
// Bits are not coherent with each other; each is just made metastability-safe.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] stab_d, stab_q;

    // Shift the raw pins through the two synchronizer stages.
    always_comb begin
        meta_d = d;
        stab_d = meta_q;
    end

    // Synchronizer flops, cleared by reset so stale pin history is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            stab_q <= '0;
        end else begin
            meta_q <= meta_d;
            stab_q <= stab_d;
        end
    end

    assign q = stab_q;

endmodule

// File: rtl/light_state_control.sv
// Occupancy-driven lamp state controller: OFF/ON/HOLD/OVERRIDE state machine
// with a hold-off timer that keeps the lamp lit after motion stops.
module light_state_control
    import light_pkg::*;
#(
    parameter  int unsigned HOLD_CYCLES = 16,
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Motion,
    input  logic             Dark,
    input  logic             Manual_On,
    output logic [1:0]       Present_State,
    output logic [CNT_W-1:0] Hold_Count
);

    // Entering HOLD loads HOLD_CYCLES-1 and leaves when the count is zero,
    // so HOLD lasts exactly HOLD_CYCLES cycles without motion.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [IN_W-1:0]  pins_raw;
    logic [IN_W-1:0]  pins_sync;
    logic             motion_s;
    logic             dark_s;
    logic             manual_s;

    light_state_t     state_d, state_q;
    logic [CNT_W-1:0] hold_cnt_d, hold_cnt_q;

    assign pins_raw[IN_MOTION] = Motion;
    assign pins_raw[IN_DARK]   = Dark;
    assign pins_raw[IN_MANUAL] = Manual_On;

    sync_2ff #(
        .WIDTH (IN_W)
    ) u_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (pins_raw),
        .q   (pins_sync)
    );

    assign motion_s = pins_sync[IN_MOTION];
    assign dark_s   = pins_sync[IN_DARK];
    assign manual_s = pins_sync[IN_MANUAL];

    // Next-state and hold-counter logic; the counter is zero outside HOLD.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        if (manual_s) begin
            state_d = ST_OVERRIDE;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // Darkness only gates turning on, never turning off.
                    if (motion_s && dark_s) begin
                        state_d = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!motion_s) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (motion_s) begin
                        state_d = ST_ON;
                    end else if (hold_cnt_q != '0) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = hold_cnt_q - CNT_W'(1);
                    end else begin
                        state_d = ST_OFF;
                    end
                end
                ST_OVERRIDE: begin
                    // Override released: fall into the normal hold-off period.
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_LOAD;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // State register and hold counter with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_OFF;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign Present_State = state_q;
    assign Hold_Count    = hold_cnt_q;

endmodule

// File: tb/tb_light_state_control.sv
// Scoreboard bench for light_state_control with HOLD_CYCLES=4.
module tb_light_state_control;

    localparam int HC = 4;
    localparam int CW = 2;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Motion = 1'b0;
    logic          Dark = 1'b0;
    logic          Manual_On = 1'b0;
    logic [1:0]    Present_State;
    logic [CW-1:0] Hold_Count;

    light_state_control #(
        .HOLD_CYCLES (HC)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Motion        (Motion),
        .Dark          (Dark),
        .Manual_On     (Manual_On),
        .Present_State (Present_State),
        .Hold_Count    (Hold_Count)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]    st;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   done   = 0;

    // Reference model: pin history seen through a two-deep delay, and the
    // lamp described as "lit" plus "cycles idle since last motion/override".
    bit [2:0] dl1, dl2;        // {manual, dark, motion}
    bit       m_lit, m_ovr;
    int       m_idle;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of pins (at a falling edge), predict the state that
    // the following rising edge produces, and wait for the next falling edge.
    task automatic step(input bit rst, input bit mo, input bit dk, input bit man);
        bit [2:0] use_v;
        exp_t     e;
        Reset = rst; Motion = mo; Dark = dk; Manual_On = man;
        e.st = 2'd0; e.cnt = '0;
        if (rst) begin
            dl1 = '0; dl2 = '0;
            m_lit = 0; m_ovr = 0; m_idle = 0;
        end else begin
            use_v = dl2;
            dl2   = dl1;
            dl1   = {man, dk, mo};
            if (use_v[2]) begin
                m_lit = 1; m_ovr = 1; m_idle = 0;
                e.st = 2'd3;
            end else if (m_ovr) begin
                m_ovr = 0; m_idle = 1;
                e.st = 2'd2; e.cnt = CW'(HC - 1);
            end else if (!m_lit) begin
                if (use_v[0] && use_v[1]) begin
                    m_lit = 1; m_idle = 0; e.st = 2'd1;
                end
            end else if (use_v[0]) begin
                m_idle = 0; e.st = 2'd1;
            end else begin
                m_idle++;
                if (m_idle <= HC) begin
                    e.st = 2'd2; e.cnt = CW'(HC - m_idle);
                end else begin
                    m_lit = 0;
                end
            end
        end
        exp_q.push_back(e);
        @(negedge Clock);
    endtask

    task automatic steps(input int n, input bit mo, input bit dk, input bit man);
        for (int i = 0; i < n; i++) step(0, mo, dk, man);
    endtask

    // Monitor: compare DUT outputs just after every rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (done) break;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: no expectation queued at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (Present_State !== e.st || Hold_Count !== e.cnt) begin
                    errors++;
                    $display("FAIL cycle_compare: got state=%b cnt=%0d expected state=%b cnt=%0d at %0t",
                             Present_State, Hold_Count, e.st, e.cnt, $time);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset for two cycles.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_state", Present_State, 0);
        check("reset_count", Hold_Count, 0);

        // Dark with motion: ON after the third edge, then a full hold-off.
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        check("on_not_yet", Present_State, 0);
        step(0, 1, 1, 0);
        check("on_after_3_edges", Present_State, 1);
        steps(3, 0, 1, 0);
        check("hold_entry_state", Present_State, 2);
        check("hold_entry_count", Hold_Count, 3);
        steps(3, 0, 1, 0);
        check("hold_last_count", Hold_Count, 0);
        check("hold_last_state", Present_State, 2);
        step(0, 0, 1, 0);
        check("hold_expired", Present_State, 0);

        // Motion in daylight never turns the lamp on.
        steps(10, 1, 0, 0);
        check("daylight_motion", Present_State, 0);
        steps(3, 0, 0, 0);

        // Motion returns mid-HOLD at count 2: back to ON, counter cleared.
        steps(3, 1, 1, 0);
        steps(2, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("retrigger_hold_cnt", Hold_Count, 2);
        step(0, 1, 0, 0);
        check("retrigger_state", Present_State, 1);
        check("retrigger_count", Hold_Count, 0);

        // Override during HOLD, release into a fresh hold-off.
        steps(2, 0, 0, 0);
        steps(3, 0, 0, 1);
        check("override_state", Present_State, 3);
        check("override_count", Hold_Count, 0);
        steps(3, 0, 0, 0);
        check("override_release_state", Present_State, 2);
        check("override_release_count", Hold_Count, 3);
        steps(4, 0, 0, 0);
        check("override_hold_done", Present_State, 0);

        // Manual and motion together from OFF: override wins.
        steps(3, 1, 1, 1);
        check("manual_beats_motion", Present_State, 3);
        steps(8, 0, 0, 0);

        // Reset mid-HOLD, then a motion pulse right after reset.
        steps(3, 1, 1, 0);
        steps(4, 0, 1, 0);
        check("pre_reset_count", Hold_Count, 2);
        step(1, 0, 1, 0);
        check("reset_mid_hold_state", Present_State, 0);
        check("reset_mid_hold_count", Hold_Count, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        check("pulse_in_sync", Present_State, 0);
        step(0, 0, 1, 0);
        check("pulse_through_sync", Present_State, 1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 11) == 0));
        end

        done = 1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/light_state_control.md
LIGHT_STATE_CONTROL -- requirements
Module: light_state_control

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16, giving the number of cycles the light stays on after motion ends; legal range 1..65535.
REQ-002 SHALL have localparam CNT_W = max(1, clog2(HOLD_CYCLES)), the hold counter width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Clock  input  1  system clock; all state changes occur on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Motion  input  1  occupancy sensor, asynchronous to Clock.
REQ-007 Dark  input  1  ambient-light sensor (1 = dark), asynchronous to Clock.
REQ-008 Manual_On  input  1  wall override switch (1 = force on), asynchronous to Clock.
REQ-009 Present_State  output  2  registered FSM state; feeds the lamp output decoder, where any nonzero state means lamp on.
REQ-010 Hold_Count  output  CNT_W  registered remaining hold cycles; nonzero only in HOLD.

Function
REQ-011 SHALL pass Motion, Dark and Manual_On each through a 2-flop synchronizer before any use.
REQ-012 SHALL encode states as OFF=2'b00, ON=2'b01, HOLD=2'b10, OVERRIDE=2'b11.
REQ-013 SHALL update Present_State on the rising edge after the synchronized inputs change. A pin change is therefore visible on Present_State after the 3rd rising edge.
REQ-014 Priority, from any state: synchronized Manual_On=1 -> OVERRIDE next cycle, with Hold_Count=0.
REQ-015 OFF: synchronized Motion & Dark -> ON; otherwise stay OFF.
REQ-016 ON: Motion=1 -> stay ON; Motion=0 -> HOLD, loading Hold_Count=HOLD_CYCLES-1.
REQ-017 HOLD: Motion=1 -> ON with Hold_Count=0, regardless of Dark.
REQ-018 HOLD: Motion=0 and Hold_Count>0 -> stay in HOLD and decrement Hold_Count.
REQ-019 HOLD: Motion=0 and Hold_Count=0 -> OFF.
REQ-020 HOLD SHALL therefore last exactly HOLD_CYCLES cycles when no motion occurs. With HOLD_CYCLES=1, HOLD lasts one cycle.
REQ-021 OVERRIDE: Manual_On=1 -> stay; Manual_On=0 -> HOLD, loading Hold_Count=HOLD_CYCLES-1.
REQ-022 Dark SHALL only gate the OFF->ON transition; Dark falling in ON or HOLD SHALL NOT turn the lamp off early.
REQ-023 Hold_Count SHALL never wrap below 0; in states other than HOLD it SHALL be 0.
REQ-024 Simultaneous Motion and Manual_On: Manual_On wins (REQ-014).
REQ-025 The unreachable encoding SHALL NOT exist; all four codes are legal, and the default branch SHALL go to OFF.

Reset
REQ-026 Reset=1 at a rising edge SHALL set Present_State=OFF and Hold_Count=0, and clear all synchronizer flops to 0.
REQ-027 Reset SHALL override all inputs in any state, including mid-HOLD and OVERRIDE.
REQ-028 After Reset deasserts, normal operation SHALL resume on the next edge, subject to the synchronizer latency.

Structure
REQ-029 The state encodings (OFF/ON/HOLD/OVERRIDE) SHALL be defined in shared package light_pkg, which is also used by the lamp output decoder.
REQ-030 The synchronizer SHALL be a sub-module sync_2ff, parameterised by width; one 3-bit instance covers all inputs.
REQ-031 The state register, next-state logic and hold counter SHALL reside in light_state_control; the lamp output decoding SHALL remain a separate downstream block.

Verification (HOLD_CYCLES=4)
REQ-032 Reset for 2 cycles -> Present_State=00, Hold_Count=0.
REQ-033 Dark=1, Motion rises at edge 0 -> Present_State=01 after edge 3. Motion then falls -> 10 with Hold_Count 3,2,1,0 over 4 cycles, then 00.
REQ-034 Dark=0, Motion=1 for 10 cycles -> Present_State stays 00.
REQ-035 In HOLD at Hold_Count=2, Motion re-asserts -> 01 with Hold_Count=0 (3 edges after the pin change); no drop to 00.
REQ-036 Manual_On=1 during HOLD -> 11. Release -> 10 with Hold_Count=3, then 00 after 4 cycles. Manual_On and Motion asserted together from OFF -> 11.
REQ-037 Reset pulsed during HOLD with Hold_Count=2 -> 00 and 0 on the next edge; a Motion pulse in the cycle after reset has no effect until it passes the synchronizer.
